// File: rtl/hog_pkg.sv
// Shared defaults and arithmetic helpers for the HOG cell histogram pipeline.
package hog_pkg;
  localparam int NUM_BINS_DEF  = 9;
  localparam int BIN_WIDTH_DEF = 16;
  localparam int CELL_SIZE_DEF = 8;
  localparam int HIST_W_DEF    = NUM_BINS_DEF * BIN_WIDTH_DEF;

  // Unsigned add clamped to the largest w-bit value (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction
endpackage

// File: rtl/hist_row_ram.sv
// Row buffer of partial cell histograms: 1 write port, 1 registered read port.
module hist_row_ram #(
  parameter int DEPTH = 79,
  parameter int WIDTH = 144,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/cell_histogram.sv
// Accumulates binned gradient magnitudes into per-cell orientation histograms and
// emits one histogram word per completed cell in raster order.
module cell_histogram import hog_pkg::*; #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 638,
  parameter int FRAME_HEIGHT = 478,
  parameter int CELL_SIZE    = CELL_SIZE_DEF,
  parameter int NUM_BINS     = NUM_BINS_DEF,
  parameter int BIN_WIDTH    = BIN_WIDTH_DEF,
  localparam int CELLS_X     = FRAME_WIDTH / CELL_SIZE,
  localparam int CELLS_Y     = FRAME_HEIGHT / CELL_SIZE,
  localparam int HW          = NUM_BINS * BIN_WIDTH,
  localparam int XW          = (CELLS_X > 1) ? $clog2(CELLS_X) : 1,
  localparam int YW          = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  input  logic [DATA_WIDTH-1:0] magnitude,
  input  logic [3:0]            bin,
  output logic                  hist_valid,
  input  logic                  hist_ready,
  output logic [HW-1:0]         hist,
  output logic [XW-1:0]         cell_x,
  output logic [YW-1:0]         cell_y,
  output logic                  hist_last
);
  localparam int XCW = $clog2(FRAME_WIDTH);
  localparam int YCW = $clog2(FRAME_HEIGHT);
  localparam int PW  = $clog2(CELL_SIZE);
  localparam int CXW = $clog2(CELLS_X + 1);
  localparam int CYW = $clog2(CELLS_Y + 1);
  localparam int AW  = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;

  logic [XCW-1:0] x_q, x_d;
  logic [YCW-1:0] y_q, y_d;
  logic [PW-1:0]  px_q, px_d, py_q, py_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic [NUM_BINS-1:0][BIN_WIDTH-1:0] acc_q, acc_d, acc_nxt, ram_rb;
  logic [HW-1:0]  hist_q, hist_d, ram_rdata;
  logic [XW-1:0]  cell_x_q, cell_x_d;
  logic [YW-1:0]  cell_y_q, cell_y_d;
  logic           hvld_q, hvld_d, last_q, last_d, rdy_q;
  logic           take, in_region, seg_end, row_end, acc_en, load, ram_we;
  logic [CXW-1:0] rsel;
  logic [AW-1:0]  raddr;

  assign bin_ready = rdy_q && (!hvld_q || hist_ready);
  assign take      = bin_valid && bin_ready;
  assign in_region = (cx_q < CXW'(CELLS_X)) && (cy_q < CYW'(CELLS_Y));
  assign seg_end   = (px_q == PW'(CELL_SIZE - 1));
  assign row_end   = (py_q == PW'(CELL_SIZE - 1));
  assign acc_en    = take && in_region;
  assign load      = acc_en && seg_end && row_end;
  assign ram_we    = acc_en && seg_end && !row_end;

  // Waiting at a segment start: keep reading this column; mid-segment: prefetch the next.
  assign rsel  = (px_q == '0) ? cx_q : cx_q + 1'b1;
  assign raddr = (rsel < CXW'(CELLS_X)) ? rsel[AW-1:0] : '0;
  assign ram_rb = ram_rdata;

  for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
    logic [BIN_WIDTH-1:0] base;
    assign base = (px_q != '0) ? acc_q[k] : ((py_q == '0) ? '0 : ram_rb[k]);
    assign acc_nxt[k] = (bin == 4'(k))
                      ? BIN_WIDTH'(sat_add(32'(base), 32'(magnitude), BIN_WIDTH)) : base;
  end

  hist_row_ram #(.DEPTH(CELLS_X), .WIDTH(HW)) u_row_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cx_q[AW-1:0]),
    .wdata (acc_nxt),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    x_d = x_q; y_d = y_q; px_d = px_q; py_d = py_q; cx_d = cx_q; cy_d = cy_q;
    if (take) begin
      if (x_q == XCW'(FRAME_WIDTH - 1)) begin
        x_d = '0; px_d = '0; cx_d = '0;
        if (y_q == YCW'(FRAME_HEIGHT - 1)) begin
          y_d = '0; py_d = '0; cy_d = '0;
        end else begin
          y_d = y_q + 1'b1;
          if (row_end) begin py_d = '0; cy_d = cy_q + 1'b1; end
          else py_d = py_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
        if (seg_end) begin px_d = '0; cx_d = cx_q + 1'b1; end
        else px_d = px_q + 1'b1;
      end
    end
  end

  always_comb begin
    acc_d    = acc_en ? acc_nxt : acc_q;
    hist_d   = hist_q;
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    last_d   = last_q;
    hvld_d   = hvld_q && !hist_ready;
    if (load) begin
      hist_d   = acc_nxt;
      cell_x_d = cx_q[XW-1:0];
      cell_y_d = cy_q[YW-1:0];
      last_d   = (cx_q == CXW'(CELLS_X - 1)) && (cy_q == CYW'(CELLS_Y - 1));
      hvld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0; y_q <= '0; px_q <= '0; py_q <= '0; cx_q <= '0; cy_q <= '0;
      acc_q <= '0; hist_q <= '0; cell_x_q <= '0; cell_y_q <= '0;
      last_q <= 1'b0; hvld_q <= 1'b0; rdy_q <= 1'b0;
    end else begin
      x_q <= x_d; y_q <= y_d; px_q <= px_d; py_q <= py_d; cx_q <= cx_d; cy_q <= cy_d;
      acc_q <= acc_d; hist_q <= hist_d; cell_x_q <= cell_x_d; cell_y_q <= cell_y_d;
      last_q <= last_d; hvld_q <= hvld_d; rdy_q <= 1'b1;
    end
  end

  assign hist_valid = hvld_q;
  assign hist       = hist_q;
  assign cell_x     = cell_x_q;
  assign cell_y     = cell_y_q;
  assign hist_last  = last_q;
endmodule
